// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: combinational instruction-memory port plus the valid/ready path to decode.
interface fetch_ctrl_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_ready;

  modport master (
    output imem_addr,
    input  imem_instr,
    output if_valid,
    output if_instr,
    output if_pc,
    input  if_ready
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output if_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: fpc drives imem, words land in a 2-entry queue, head visible 1 cycle after enqueue;
// fetch stalls while the queue is full and if_ready is low. FETCH_PERF_CNT_EN builds the fetch_count counter.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [15:0]        redirect_pc,
  fetch_ctrl_if.master       bus,
  output logic [1:0]         state,
  output logic [31:0]        fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic        run;

  logic [15:0] fpc;
  logic [1:0]  cnt;
  logic [15:0] head_instr;
  logic [15:0] head_pc;
  logic [15:0] tail_instr;
  logic [15:0] tail_pc;
  logic        deq;
  logic        enq;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // halt_req outranks start once the core has been started; IDLE only listens to start
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (halt_req) state_d = S_HALT;
      S_HALT:  if (!halt_req && start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    state = state_q;
    run   = 1'b0;
    if (state_q == S_RUN) run = 1'b1;
  end

  assign deq = (cnt != 2'd0) && bus.if_ready;
  assign enq = run && !halt_req && !redirect_valid && ((cnt != 2'd2) || deq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc <= RESET_PC;
    end else if (redirect_valid) begin
      fpc <= redirect_pc & 16'hFFFE;
    end else if (enq) begin
      fpc <= fpc + 16'd2;
    end
  end

  // Head/tail shift queue: the head register feeds if_* directly so decode never sees imem combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 2'd0;
      head_instr <= 16'h0000;
      head_pc    <= 16'h0000;
      tail_instr <= 16'h0000;
      tail_pc    <= 16'h0000;
    end else if (redirect_valid) begin
      cnt <= 2'd0;
    end else begin
      if (enq && ((cnt == 2'd0) || ((cnt == 2'd1) && deq))) begin
        head_instr <= bus.imem_instr;
        head_pc    <= fpc;
      end else if (deq) begin
        head_instr <= tail_instr;
        head_pc    <= tail_pc;
      end
      if (enq && (((cnt == 2'd1) && !deq) || ((cnt == 2'd2) && deq))) begin
        tail_instr <= bus.imem_instr;
        tail_pc    <= fpc;
      end
      cnt <= cnt + {1'b0, enq} - {1'b0, deq};
    end
  end

  assign bus.imem_addr = fpc;
  assign bus.if_valid  = (cnt != 2'd0);
  assign bus.if_instr  = head_instr;
  assign bus.if_pc     = head_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
    end else if (enq) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, streaming, backpressure, redirect, wrap, halt/start, counter.
module tb_fetch_ctrl;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [1:0]  state;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .state          (state),
    .fetch_count    (fetch_count)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], ~a[15:8]} ^ 16'h3C5A;
  endfunction

  assign bus.imem_instr = mem_word(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [15:0] pc, input logic [15:0] addr);
    chk({tag, "_vld"}, {31'd0, bus.if_valid}, 32'd1);
    chk({tag, "_pc"}, {16'd0, bus.if_pc}, {16'd0, pc});
    chk({tag, "_instr"}, {16'd0, bus.if_instr}, {16'd0, mem_word(pc)});
    chk({tag, "_addr"}, {16'd0, bus.imem_addr}, {16'd0, addr});
  endtask

  initial begin
    logic [31:0] cnt_exp;
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000; bus.if_ready = 1'b0;
    tick(); tick();
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_addr", {16'd0, bus.imem_addr}, 32'h0);
    chk("rst_vld", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_instr", {16'd0, bus.if_instr}, 32'h0);
    chk("rst_pc", {16'd0, bus.if_pc}, 32'h0);
    chk("rst_cnt", fetch_count, 32'h0);
    rst_n = 1'b1;

    // start, stream with if_ready high
    start = 1'b1; bus.if_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("start_state", {30'd0, state}, 32'd1);
    chk("start_vld", {31'd0, bus.if_valid}, 32'd0);
    chk("start_addr", {16'd0, bus.imem_addr}, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      head("stream", 16'(2 * i), 16'(2 * i + 2));
      tick();
    end

    // asynchronous reset mid-operation
    rst_n = 1'b0;
    #2;
    chk("mid_rst_vld", {31'd0, bus.if_valid}, 32'd0);
    chk("mid_rst_state", {30'd0, state}, 32'd0);
    chk("mid_rst_addr", {16'd0, bus.imem_addr}, 32'h0);
    chk("mid_rst_pc", {16'd0, bus.if_pc}, 32'h0);
    chk("mid_rst_cnt", fetch_count, 32'h0);
    rst_n = 1'b1;
    bus.if_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;

    // backpressure: queue fills with 0,2 and fetch stalls at 4
    tick(); tick(); tick(); tick(); tick();
    head("bp_full", 16'h0000, 16'h0004);
    bus.if_ready = 1'b1;
    tick(); head("bp_rel1", 16'h0002, 16'h0006);
    tick(); head("bp_rel2", 16'h0004, 16'h0008);
    tick(); head("bp_rel3", 16'h0006, 16'h000A);

    // redirect with a full queue and a dequeue pending
    redirect_valid = 1'b1; redirect_pc = 16'h0101;
    tick();
    redirect_valid = 1'b0;
    chk("redir_vld", {31'd0, bus.if_valid}, 32'd0);
    chk("redir_addr", {16'd0, bus.imem_addr}, 32'h0100);
    tick(); head("redir_t0", 16'h0100, 16'h0102);
    tick(); head("redir_t1", 16'h0102, 16'h0104);

    // address wrap
    redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_vld", {31'd0, bus.if_valid}, 32'd0);
    tick(); head("wrap0", 16'hFFFC, 16'hFFFE);
    tick(); head("wrap1", 16'hFFFE, 16'h0000);
    tick(); head("wrap2", 16'h0000, 16'h0002);

    // halt with two queued entries: queue drains, fpc frozen
    bus.if_ready = 1'b0;
    tick(); head("pre_halt", 16'h0000, 16'h0004);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt_state", {30'd0, state}, 32'd2);
    head("halt_hold", 16'h0000, 16'h0004);
    bus.if_ready = 1'b1;
    tick(); head("halt_drain1", 16'h0002, 16'h0004);
    tick();
    chk("halt_empty", {31'd0, bus.if_valid}, 32'd0);
    chk("halt_addr", {16'd0, bus.imem_addr}, 32'h0004);
    chk("halt_state2", {30'd0, state}, 32'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("resume_state", {30'd0, state}, 32'd1);
    chk("resume_vld", {31'd0, bus.if_valid}, 32'd0);
    tick(); head("resume", 16'h0004, 16'h0006);

    // halt_req and start together from RUN
    halt_req = 1'b1; start = 1'b1;
    tick();
    halt_req = 1'b0; start = 1'b0;
    chk("both_state", {30'd0, state}, 32'd2);
    chk("both_addr", {16'd0, bus.imem_addr}, 32'h0006);

    // 12 enqueues since the mid-run reset (9 delivered/pending, 3 flushed)
`ifdef FETCH_PERF_CNT_EN
    cnt_exp = 32'd12;
`else
    cnt_exp = 32'd0;
`endif
    chk("fetch_count", fetch_count, cnt_exp);

    // redirect in HALT moves fpc but does not fetch
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("halt_redir_state", {30'd0, state}, 32'd2);
    chk("halt_redir_vld", {31'd0, bus.if_valid}, 32'd0);
    chk("halt_redir_addr", {16'd0, bus.imem_addr}, 32'h0200);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); head("halt_redir_t", 16'h0200, 16'h0202);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
